mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between three requesters: instruction fetch, the load path of the mem stage, and store-buffer drain at commit.
- Sits between `fetch`/`mem` and the memory model. Allows one outstanding transaction.
- Arbitrates with fixed priority (load > store > fetch).
- Drops in-flight fetch responses on a commit-time branch flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied fetch cycles before fetch is promoted (only used with the optional feature)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  commit branch taken; kills fetch traffic
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- ld_req_i  in  1  load request
- ld_addr_i  in  ADDR_W  load address
- ld_gnt_o  out  1  load accepted
- ld_rvalid_o  out  1  load data valid
- ld_rdata_o  out  DATA_W  load data
- st_req_i  in  1  store-drain request
- st_addr_i  in  ADDR_W  store address
- st_wdata_i  in  DATA_W  store data
- st_be_i  in  DATA_W/8  byte enables
- st_gnt_o  out  1  store accepted
- st_ack_o  out  1  store write completed
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  DATA_W/8  byte enables (all ones on reads)
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Requester rule: a requester holds req/addr/data stable until its gnt. A requester may drop req before gnt only on flush (fetch).
- States:
  - IDLE: no transaction active.
  - REQ: owner locked, mem_req_o=1, waiting for mem_gnt_i.
  - WAIT: granted, waiting for mem_rvalid_i.
- IDLE transitions:
  - If any req is present, select a winner combinationally: ld > st > if.
  - Drive mem_req_o/addr/we/wdata/be from the winner in the same cycle.
  - If mem_gnt_i=1: pulse the winner's gnt that cycle and go to WAIT.
  - Else: latch the owner and go to REQ.
- REQ: no re-arbitration; memory outputs come from the latched owner's live inputs. On mem_gnt_i: pulse the owner's gnt and go to WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i:
  - Pulse the owner's rvalid/ack for one cycle.
  - rdata is passed through combinationally.
  - Return to IDLE.
  - The next arbitration happens in the following cycle. Minimum issue interval is therefore 2 cycles with zero-latency memory.
- The response arrives at the earliest 1 cycle after gnt.
- rdata outputs are 0 when the corresponding rvalid=0.
- Flush:
  - IDLE: fetch is excluded from arbitration that cycle; ld/st proceed normally.
  - REQ with owner=fetch: mem_req_o is forced to 0 that cycle, no gnt is issued, and the state goes to IDLE.
  - WAIT with owner=fetch: set a drop flag. The response is consumed from memory but if_rvalid_o stays 0. The flag clears on return to IDLE.
  - Flush is ignored when owner is ld/st.
- Flush and mem_rvalid_i in the same cycle for a fetch in WAIT: the response is dropped.
- Reset values: state IDLE, owner none, drop flag 0, starvation counter 0. All outputs are 0 during and after reset.
- Reset asserted mid-transaction: abandon the transaction immediately. No response is forwarded after reset release.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside IDLE/REQ is ignored.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments each cycle that if_req_i=1 and fetch loses arbitration in IDLE.
  - The counter saturates at STARVE_LIMIT.
  - At STARVE_LIMIT, fetch has top priority for the next IDLE arbitration.
  - The counter clears on fetch gnt or flush.
- Without the macro: strict fixed priority and no counter logic.

Test Plan:
- Single fetch, zero-wait memory:
  - Stimulus: if_req=1, addr=0x100; mem_gnt=1 in that cycle; mem_rvalid with rdata=0x00000013 one cycle later.
  - Response: if_gnt pulses in cycle 0; if_rvalid=1 with if_rdata=0x13 in cycle 1.
- Simultaneous ld, st and if in IDLE:
  - Response: order of grants is ld, then st, then if.
  - st issue has mem_we=1, be=0xF, wdata=0xDEADBEEF.
  - st_ack is pulsed when its response returns.
- Memory stalls grant 3 cycles on a load:
  - Response: mem_req stays 1 with a stable address.
  - A new st_req during REQ does not steal ownership.
  - ld_gnt occurs only on the 4th cycle.
- Fetch in WAIT, flush_i pulsed, response 2 cycles later:
  - Response: if_rvalid stays 0; the arbiter returns to IDLE.
  - A following ld is granted normally.
- Reset asserted during WAIT of a load:
  - Response: all outputs are 0 immediately.
  - A late mem_rvalid after reset release produces no ld_rvalid.
- MEM_ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=4:
  - Stimulus: continuous ld_req with if_req held.
  - Response: fetch is granted after 4 denied arbitrations. Without the macro, fetch is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch, load and store drain.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                flush_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ld_req_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    output logic                ld_gnt_o,
    output logic                ld_rvalid_o,
    output logic [DATA_W-1:0]   ld_rdata_o,
    input  logic                st_req_i,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_wdata_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    output logic                st_gnt_o,
    output logic                st_ack_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    // Handshake: a request is accepted in the cycle mem_req_o and mem_gnt_i are both high;
    // the requester holds req/addr/data until its gnt pulse, and exactly one response
    // (rvalid/ack) follows each gnt unless a fetch is killed by flush_i.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_t;

    state_t r_state, w_state_nxt;
    owner_t r_owner, w_owner_nxt, w_sel;
    logic   r_drop, w_drop_nxt;
    logic   w_issue_gnt;
    logic   w_resp;
    logic   w_if_ok;
    logic   w_starved;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_drop_nxt  = r_drop;
        w_sel       = OWN_NONE;
        w_issue_gnt = 1'b0;
        w_resp      = 1'b0;
        w_if_ok     = if_req_i && !flush_i;
        // Everything is held quiet while reset is asserted, including the combinational paths.
        if (rstn_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_starved && w_if_ok) w_sel = OWN_IF;
                    else if (ld_req_i)        w_sel = OWN_LD;
                    else if (st_req_i)        w_sel = OWN_ST;
                    else if (w_if_ok)         w_sel = OWN_IF;
                    if (w_sel != OWN_NONE) begin
                        w_owner_nxt = w_sel;
                        w_issue_gnt = mem_gnt_i;
                        w_state_nxt = mem_gnt_i ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush_i && r_owner == OWN_IF) begin
                        w_state_nxt = S_IDLE;
                        w_owner_nxt = OWN_NONE;
                    end else begin
                        w_sel       = r_owner;
                        w_issue_gnt = mem_gnt_i;
                        if (mem_gnt_i) w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_i && r_owner == OWN_IF) w_drop_nxt = 1'b1;
                    if (mem_rvalid_i) begin
                        w_resp      = !(r_drop || (flush_i && r_owner == OWN_IF));
                        w_state_nxt = S_IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_drop_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_drop_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if_gnt_o    = 1'b0;
        ld_gnt_o    = 1'b0;
        st_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ld_rvalid_o = 1'b0;
        st_ack_o    = 1'b0;
        case (w_sel)
            OWN_IF: begin
                mem_req_o  = 1'b1;
                mem_addr_o = if_addr_i;
                mem_be_o   = '1;
                if_gnt_o   = w_issue_gnt;
            end
            OWN_LD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ld_addr_i;
                mem_be_o   = '1;
                ld_gnt_o   = w_issue_gnt;
            end
            OWN_ST: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = st_addr_i;
                mem_wdata_o = st_wdata_i;
                mem_be_o    = st_be_i;
                st_gnt_o    = w_issue_gnt;
            end
            default: ;
        endcase
        if (w_resp) begin
            case (r_owner)
                OWN_IF:  if_rvalid_o = 1'b1;
                OWN_LD:  ld_rvalid_o = 1'b1;
                OWN_ST:  st_ack_o    = 1'b1;
                default: ;
            endcase
        end
    end

    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
    assign ld_rdata_o = ld_rvalid_o ? mem_rdata_i : '0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_if_lost;

    // Counts IDLE arbitrations that a live fetch request lost.
    assign w_if_lost = (r_state == S_IDLE) && w_if_ok && (w_sel != OWN_IF);
    assign w_starved = (r_starve_cnt == LIMIT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
        end else if (if_gnt_o || flush_i) begin
            r_starve_cnt <= '0;
        end else if (w_if_lost && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Guard compiled out: fetch is never promoted (the limit is always non-negative).
    assign w_starved = (STARVE_LIMIT < 0);
`endif

endmodule
